// File: rtl/pipelined_csa_adder.sv
// ============================================================================
// Module      : pipelined_csa_adder
// Description : Parametrised pipelined carry-select adder/subtractor with
//               valid/ready handshake, signed-overflow and zero flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_csa_adder #(
  parameter int WIDTH  = 64,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int c_SEG    = WIDTH / STAGES;
  localparam int c_NSLICE = c_SEG / BLOCK;
  localparam int c_BW     = BLOCK + 1;
  localparam int c_LAST   = STAGES - 1;

  if ((STAGES < 1) || (BLOCK < 1) || ((WIDTH % (BLOCK * STAGES)) != 0)) begin : g_bad_cfg
    $error("pipelined_csa_adder: WIDTH must be a multiple of BLOCK*STAGES");
  end

  // Stage registers: index k holds the state leaving segment k.
  logic [STAGES-1:0][WIDTH-1:0] r_a;
  logic [STAGES-1:0][WIDTH-1:0] r_b;
  logic [STAGES-1:0][WIDTH-1:0] r_sum;
  logic [STAGES-1:0]            r_c;
  logic [STAGES-1:0]            r_vld;
  logic                         r_ovf;
  logic                         r_zero;

  // Combinational view of each segment's inputs and outputs.
  logic [STAGES-1:0][WIDTH-1:0] w_st_a;
  logic [STAGES-1:0][WIDTH-1:0] w_st_b;
  logic [STAGES-1:0][WIDTH-1:0] w_st_sum_in;
  logic [STAGES-1:0][WIDTH-1:0] w_st_sum_out;
  logic [STAGES-1:0]            w_st_cin;
  logic [STAGES-1:0]            w_st_cout;
  logic [STAGES-1:0]            w_st_vld;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;
  logic             w_advance;
  logic             w_ovf;
  logic             w_zero;
  logic             w_unused_ok;

  assign w_b_eff   = sub ? ~b : b;
  assign w_c_eff   = cin ^ sub;
  assign w_advance = !r_vld[c_LAST] || out_ready;
  assign in_ready  = w_advance;

  genvar k, j;
  for (k = 0; k < STAGES; k++) begin : g_stage
    logic [c_SEG-1:0] w_sa;
    logic [c_SEG-1:0] w_sb;
    logic [c_SEG-1:0] w_seg;

    if (k == 0) begin : g_first
      assign w_st_a[k]      = a;
      assign w_st_b[k]      = w_b_eff;
      assign w_st_cin[k]    = w_c_eff;
      assign w_st_sum_in[k] = '0;
      assign w_st_vld[k]    = in_valid;
    end else begin : g_next
      assign w_st_a[k]      = r_a[k-1];
      assign w_st_b[k]      = r_b[k-1];
      assign w_st_cin[k]    = r_c[k-1];
      assign w_st_sum_in[k] = r_sum[k-1];
      assign w_st_vld[k]    = r_vld[k-1];
    end

    assign w_sa = w_st_a[k][k*c_SEG +: c_SEG];
    assign w_sb = w_st_b[k][k*c_SEG +: c_SEG];

    for (j = 0; j < c_NSLICE; j++) begin : g_slice
      logic             w_ci;
      logic             w_co;
      logic [BLOCK-1:0] w_s;

      if (j == 0) begin : g_ripple
        assign w_ci = w_st_cin[k];
        assign {w_co, w_s} = {1'b0, w_sa[j*BLOCK +: BLOCK]} + {1'b0, w_sb[j*BLOCK +: BLOCK]}
                           + c_BW'(w_ci);
      end else begin : g_select
        // Both carry-in hypotheses are ready before the slice carry arrives.
        logic [BLOCK:0] w_s0;
        logic [BLOCK:0] w_s1;
        assign w_ci = g_slice[j-1].w_co;
        assign w_s0 = {1'b0, w_sa[j*BLOCK +: BLOCK]} + {1'b0, w_sb[j*BLOCK +: BLOCK]};
        assign w_s1 = {1'b0, w_sa[j*BLOCK +: BLOCK]} + {1'b0, w_sb[j*BLOCK +: BLOCK]}
                    + c_BW'(1);
        assign {w_co, w_s} = w_ci ? w_s1 : w_s0;
      end

      assign w_seg[j*BLOCK +: BLOCK] = w_s;
    end

    // Bits at and above this segment are still zero in the incoming partial sum.
    assign w_st_sum_out[k] = w_st_sum_in[k] | (WIDTH'(w_seg) << (k * c_SEG));
    assign w_st_cout[k]    = g_slice[c_NSLICE-1].w_co;
  end

  assign w_zero = ~|w_st_sum_out[c_LAST];
  assign w_ovf  = (w_st_a[c_LAST][WIDTH-1] == w_st_b[c_LAST][WIDTH-1]) &&
                  (w_st_sum_out[c_LAST][WIDTH-1] != w_st_a[c_LAST][WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_c    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_advance) begin
      r_vld  <= w_st_vld;
      r_a    <= w_st_a;
      r_b    <= w_st_b;
      r_sum  <= w_st_sum_out;
      r_c    <= w_st_cout;
      r_ovf  <= w_ovf;
      r_zero <= w_zero;
    end
  end

  assign out_valid = r_vld[c_LAST];
  assign sum       = r_sum[c_LAST];
  assign cout      = r_c[c_LAST];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

  // Operand bits below each segment are never read downstream.
  assign w_unused_ok = ^{r_a, r_b};

endmodule

`default_nettype wire
